// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the main-memory port arbiter.
//   arb_state_t  : arbiter FSM state (idle, I-cache owns port, D-cache owns port)
//   grant_of()   : one-hot {d_granted, i_granted} encoding of a state
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    function automatic logic [1:0] grant_of(arb_state_t st);
        logic [1:0] g;
        g = 2'b00;
        case (st)
            GNT_I:   g = 2'b01;
            GNT_D:   g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single main-memory port between the I-cache refill path
// (read-only) and the D-cache refill/writeback path. D-cache has fixed
// priority, but after MAX_D_STREAK consecutive D wins while I is waiting,
// I wins the next arbitration. Bursts are granted atomically: the owner
// keeps the port until its last beat is acked or it drops its request.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   i_req/i_addr/i_last        I-cache beat request (held until i_ack)
//   i_ack/i_rdata              I-cache beat completion and read data
//   d_req/d_we/d_addr/d_wdata/d_last   D-cache beat request
//   d_ack/d_rdata              D-cache beat completion and read data
//   mem_req/mem_we/mem_addr/mem_wdata  memory-side request
//   mem_ack/mem_rdata          memory-side completion and read data
//   grant                      registered {d_granted, i_granted}
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | port free; arbitrate between requesters, outputs all zero
// GNT_I | I-cache owns the port until last ack or request withdrawal
// GNT_D | D-cache owns the port until last ack or request withdrawal
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_last,
    output logic                  i_ack,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic                  d_last,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            grant
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

    arb_state_t          state, state_nxt;
    logic [STREAK_W-1:0] streak, streak_nxt;
    logic                d_wins;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            streak <= '0;
            grant  <= 2'b00;
        end else begin
            state  <= state_nxt;
            streak <= streak_nxt;
            grant  <= grant_of(state_nxt);
        end
    end

    // D keeps priority unless I is waiting and D has used up its streak.
    assign d_wins = d_req && !(i_req && (streak == STREAK_MAX));

    always_comb begin
        state_nxt  = state;
        streak_nxt = streak;
        i_ack      = 1'b0;
        i_rdata    = '0;
        d_ack      = 1'b0;
        d_rdata    = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state)
            IDLE: begin
                // The streak only moves when a new burst is granted.
                if (d_wins) begin
                    state_nxt = GNT_D;
                    if (i_req)
                        streak_nxt = (streak == STREAK_MAX) ? streak : streak + STREAK_ONE;
                    else
                        streak_nxt = '0;
                end else if (i_req) begin
                    state_nxt  = GNT_I;
                    streak_nxt = '0;
                end
            end

            GNT_I: begin
                mem_req  = i_req;
                mem_addr = i_addr;
                i_ack    = mem_ack;
                i_rdata  = mem_rdata;
                // Returning to IDLE after the last beat gives the one-cycle
                // gap before the next arbitration.
                if (mem_ack) begin
                    if (i_last)
                        state_nxt = IDLE;
                end else if (!i_req) begin
                    state_nxt = IDLE;
                end
            end

            GNT_D: begin
                mem_req   = d_req;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_ack     = mem_ack;
                d_rdata   = mem_rdata;
                if (mem_ack) begin
                    if (d_last)
                        state_nxt = IDLE;
                end else if (!d_req) begin
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req, i_last, d_req, d_we, d_last, mem_ack;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [DW-1:0] d_wdata, mem_rdata, i_rdata, d_rdata, mem_wdata;
    logic          i_ack, d_ack, mem_req, mem_we;
    logic [1:0]    grant;

    int checks = 0;
    int errors = 0;

    wire [133:0] all_out = {i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we,
                            mem_addr, mem_wdata, grant};

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .MAX_D_STREAK(MAXS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_last   (i_last),
        .i_ack    (i_ack),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_last   (d_last),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .grant    (grant)
    );

    task automatic drive_idle();
        i_req = 0; i_addr = '0; i_last = 0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_last = 0;
        mem_ack = 0; mem_rdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        i_req = 1; d_req = 1; d_we = 1; d_addr = 32'h44; i_addr = 32'h88;
        mem_ack = 1; mem_rdata = 32'hFFFF_FFFF; d_wdata = 32'h5555_5555;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL reset_held: outputs %h, required 0", all_out);
        end
        step(); drive_idle(); reset = 0;
        @(negedge clk);
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL reset_release: outputs %h, required 0", all_out);
        end
        step();
    endtask

    task automatic test_i_single();
        i_req = 1; i_addr = 32'h100; i_last = 1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL i1_latency: mem_req %b, required 0", mem_req);
        end
        step(); @(negedge clk);
        checks++;
        if ({mem_req, mem_we, grant, mem_addr} !== {1'b1, 1'b0, 2'b01, 32'h100}) begin
            errors++; $display("FAIL i1_grant: req/we/grant/addr %b %b %b %h, required 1 0 01 00000100",
                               mem_req, mem_we, grant, mem_addr);
        end
        step(); @(negedge clk);
        checks++;
        if (i_ack !== 1'b0) begin
            errors++; $display("FAIL i1_early_ack: i_ack %b, required 0", i_ack);
        end
        step(); mem_ack = 1; mem_rdata = 32'hDEAD_BEEF; @(negedge clk);
        checks++;
        if ({i_ack, i_rdata, d_ack} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
            errors++; $display("FAIL i1_ack: i_ack %b i_rdata %h d_ack %b, required 1 deadbeef 0",
                               i_ack, i_rdata, d_ack);
        end
        step(); i_req = 0; mem_ack = 0; mem_rdata = '0; @(negedge clk);
        checks++;
        if ({grant, i_ack} !== 3'b000) begin
            errors++; $display("FAIL i1_release: grant %b i_ack %b, required 00 0", grant, i_ack);
        end
        step(); drive_idle();
    endtask

    task automatic test_simultaneous();
        i_req = 1; i_addr = 32'h40; i_last = 1;
        d_req = 1; d_addr = 32'h80; d_last = 1;
        @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin
            errors++; $display("FAIL sim_idle: grant %b, required 00", grant);
        end
        step(); mem_ack = 1; mem_rdata = 32'h0000_A5A5; @(negedge clk);
        checks++;
        if ({grant, d_ack, i_ack, d_rdata} !== {2'b10, 1'b1, 1'b0, 32'h0000_A5A5}) begin
            errors++; $display("FAIL sim_d_first: grant %b d_ack %b i_ack %b d_rdata %h, required 10 1 0 0000a5a5",
                               grant, d_ack, i_ack, d_rdata);
        end
        step(); d_req = 0; mem_ack = 0; mem_rdata = '0; @(negedge clk);
        checks++;
        if ({grant, mem_req} !== 3'b000) begin
            errors++; $display("FAIL sim_gap: grant %b mem_req %b, required 00 0", grant, mem_req);
        end
        step(); @(negedge clk);
        checks++;
        if (grant !== 2'b01 || mem_addr !== 32'h40) begin
            errors++; $display("FAIL sim_i_second: grant %b addr %h, required 01 00000040", grant, mem_addr);
        end
        step(); mem_ack = 1; @(negedge clk);
        step(); drive_idle();
    endtask

    task automatic test_d_burst();
        int acks = 0;
        i_req = 1; i_addr = 32'h700; i_last = 1;
        d_req = 1; d_addr = 32'h300; d_last = 0;
        @(negedge clk);
        for (int beat = 0; beat < 4; beat++) begin
            step(); mem_ack = 0; mem_rdata = '0;
            d_addr = 32'h300 + 32'(4 * beat); d_last = (beat == 3);
            @(negedge clk);
            checks++;
            if (grant !== 2'b10 || i_ack !== 1'b0 || d_ack !== 1'b0) begin
                errors++; $display("FAIL dburst_wait%0d: grant %b i_ack %b d_ack %b, required 10 0 0",
                                   beat, grant, i_ack, d_ack);
            end
            step(); mem_ack = 1; mem_rdata = 32'(beat);
            @(negedge clk);
            if (d_ack === 1'b1) acks++;
            checks++;
            if (grant !== 2'b10 || i_ack !== 1'b0 || d_rdata !== 32'(beat)) begin
                errors++; $display("FAIL dburst_ack%0d: grant %b i_ack %b d_rdata %h, required 10 0 %h",
                                   beat, grant, i_ack, d_rdata, 32'(beat));
            end
        end
        checks++;
        if (acks != 4) begin
            errors++; $display("FAIL dburst_acks: %0d d acks, required 4", acks);
        end
        step(); d_req = 0; mem_ack = 0; @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin
            errors++; $display("FAIL dburst_gap: grant %b, required 00", grant);
        end
        step(); @(negedge clk);
        checks++;
        if (grant !== 2'b01) begin
            errors++; $display("FAIL dburst_then_i: grant %b, required 01", grant);
        end
        step(); mem_ack = 1; @(negedge clk);
        step(); drive_idle();
    endtask

    // Memory answers every beat at once; D re-requests back to back.
    task automatic test_streak();
        int d_run = 0;
        int rounds = 0;
        i_req = 1; i_addr = 32'h900; i_last = 1;
        d_req = 1; d_addr = 32'hA00; d_last = 1;
        for (int cyc = 0; cyc < 60 && rounds < 2; cyc++) begin
            #1 mem_ack = mem_req;
            mem_rdata = 32'(cyc);
            @(negedge clk);
            if (grant === 2'b10 && d_ack === 1'b1) d_run++;
            if (grant === 2'b01 && i_ack === 1'b1) begin
                checks++;
                if (d_run != MAXS) begin
                    errors++; $display("FAIL streak_round%0d: %0d D grants before I, required %0d",
                                       rounds, d_run, MAXS);
                end
                d_run = 0;
                rounds++;
            end
            step();
        end
        checks++;
        if (rounds != 2) begin
            errors++; $display("FAIL streak_timeout: %0d I grants seen, required 2", rounds);
        end
        drive_idle();
        step();
    endtask

    task automatic test_d_write();
        d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'h1234_5678; d_last = 1;
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (d_rdata !== '0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL wr_idle: d_rdata %h mem_req %b, required 0 0", d_rdata, mem_req);
        end
        step(); mem_rdata = '0; @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, d_ack} !== {1'b1, 1'b1, 32'h2000, 32'h1234_5678, 1'b0}) begin
            errors++; $display("FAIL wr_bus: req %b we %b addr %h wdata %h ack %b, required 1 1 00002000 12345678 0",
                               mem_req, mem_we, mem_addr, mem_wdata, d_ack);
        end
        step(); mem_ack = 1; @(negedge clk);
        checks++;
        if (d_ack !== 1'b1) begin
            errors++; $display("FAIL wr_ack: d_ack %b, required 1", d_ack);
        end
        step(); d_req = 0; mem_ack = 0; mem_rdata = 32'hCAFE_F00D; @(negedge clk);
        checks++;
        if ({d_rdata, mem_we, grant} !== '0) begin
            errors++; $display("FAIL wr_after: d_rdata %h we %b grant %b, required 0 0 00", d_rdata, mem_we, grant);
        end
        step(); drive_idle();
    endtask

    task automatic test_reset_mid_burst();
        d_req = 1; d_addr = 32'h500; d_last = 0;
        @(negedge clk);
        step(); mem_ack = 1; mem_rdata = 32'h1; @(negedge clk);
        checks++;
        if (d_ack !== 1'b1) begin
            errors++; $display("FAIL rst_beat1: d_ack %b, required 1", d_ack);
        end
        step(); mem_ack = 0; mem_rdata = '0; d_addr = 32'h504; @(negedge clk);
        checks++;
        if (grant !== 2'b10 || mem_req !== 1'b1) begin
            errors++; $display("FAIL rst_beat2: grant %b mem_req %b, required 10 1", grant, mem_req);
        end
        #1 reset = 1;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL rst_async: outputs %h, required 0", all_out);
        end
        step(); drive_idle();
        step(); reset = 0; mem_ack = 1; mem_rdata = 32'h777; @(negedge clk);
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL rst_late_ack: outputs %h, required 0", all_out);
        end
        step(); mem_ack = 0; mem_rdata = '0; i_req = 1; i_addr = 32'h600; i_last = 1;
        @(negedge clk);
        step(); @(negedge clk);
        checks++;
        if (grant !== 2'b01 || mem_addr !== 32'h600) begin
            errors++; $display("FAIL rst_i_grant: grant %b addr %h, required 01 00000600", grant, mem_addr);
        end
        step(); mem_ack = 1; mem_rdata = 32'h1357_9BDF; @(negedge clk);
        checks++;
        if (i_ack !== 1'b1 || i_rdata !== 32'h1357_9BDF) begin
            errors++; $display("FAIL rst_i_ack: i_ack %b i_rdata %h, required 1 13579bdf", i_ack, i_rdata);
        end
        step(); drive_idle();
    endtask

    // Random traffic against a reference model of the port ownership rules.
    // owner: 0 = nobody, 1 = I-cache, 2 = D-cache.
    task automatic test_random(int ncyc);
        int owner = 0, streak = 0, mwait = 0;
        int i_left = 0, i_gap = 0, d_left = 0, d_gap = 0;
        logic [AW-1:0] i_cur = '0, d_cur = '0;
        logic          d_wr = 0;
        logic [DW-1:0] d_dat = '0;
        logic [133:0]  exp_out;
        logic          e_i_ack, e_d_ack;
        reset = 1; drive_idle();
        step(); reset = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (i_left == 0 && i_gap == 0) begin
                i_left = $urandom_range(1, 4); i_cur = $urandom & 32'hFFFF_FFF0;
            end
            if (d_left == 0 && d_gap == 0) begin
                d_left = $urandom_range(1, 4); d_cur = $urandom & 32'hFFFF_FFF0;
                d_wr = 1'($urandom); d_dat = $urandom;
            end
            i_req = (i_left > 0); i_addr = i_cur; i_last = (i_left == 1);
            d_req = (d_left > 0); d_addr = d_cur; d_last = (d_left == 1);
            d_we = d_wr; d_wdata = d_dat;
            if (i_req && $urandom_range(0, 31) == 0) begin
                i_req = 0; i_left = 0; i_gap = $urandom_range(1, 3);
            end
            if (d_req && $urandom_range(0, 31) == 0) begin
                d_req = 0; d_left = 0; d_gap = $urandom_range(1, 3);
            end
            mem_ack = 0; mem_rdata = $urandom;
            if ((owner == 1 && i_req) || (owner == 2 && d_req)) begin
                if (mwait == 0) begin
                    mem_ack = 1; mwait = $urandom_range(0, 2);
                end else begin
                    mwait--;
                end
            end else if (owner == 0 && $urandom_range(0, 7) == 0) begin
                mem_ack = 1;
            end

            @(negedge clk);
            e_i_ack = (owner == 1) && mem_ack;
            e_d_ack = (owner == 2) && mem_ack;
            if (owner == 1)
                exp_out = {mem_ack, mem_rdata, 1'b0, 32'h0, i_req, 1'b0, i_addr, 32'h0, 2'b01};
            else if (owner == 2)
                exp_out = {1'b0, 32'h0, mem_ack, mem_rdata, d_req, d_we, d_addr, d_wdata, 2'b10};
            else
                exp_out = '0;
            checks++;
            if (all_out !== exp_out) begin
                errors++; $display("FAIL rand_c%0d: outputs %h, required %h (owner %0d)", c, all_out, exp_out, owner);
            end

            case (owner)
                0: begin
                    if (d_req && !(i_req && streak == MAXS)) begin
                        owner = 2;
                        streak = i_req ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
                    end else if (i_req) begin
                        owner = 1; streak = 0;
                    end
                end
                1: if (mem_ack ? i_last : !i_req) owner = 0;
                default: if (mem_ack ? d_last : !d_req) owner = 0;
            endcase

            if (e_i_ack) begin
                i_left--; i_cur += 4;
                if (i_left == 0) i_gap = $urandom_range(0, 3);
            end else if (i_left == 0 && i_gap > 0) begin
                i_gap--;
            end
            if (e_d_ack) begin
                d_left--; d_cur += 4; d_dat = $urandom;
                if (d_left == 0) d_gap = $urandom_range(0, 1);
            end else if (d_left == 0 && d_gap > 0) begin
                d_gap--;
            end
            step();
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_i_single();
        test_simultaneous();
        test_d_burst();
        test_streak();
        test_d_write();
        test_reset_mid_burst();
        test_random(3000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
